// File: rtl/imm_encoder_pkg.sv
// imm_enc_pkg: shared types and helpers for the instruction-word assembler.
//   fmt_t      - 3-bit immediate format code (FMT_I/S/B/U/J, 5-7 invalid)
//   payload_t  - word carried through the skid buffer {inst, err}
//   fits_signed- true when v[31:lsb] are all equal (value fits a signed field)
// Optional feature macro used elsewhere: IMM_ENC_JU_EN.
package imm_enc_pkg;

  typedef logic [2:0] fmt_t;

  localparam fmt_t FMT_I = 3'd0;
  localparam fmt_t FMT_S = 3'd1;
  localparam fmt_t FMT_B = 3'd2;
  localparam fmt_t FMT_U = 3'd3;
  localparam fmt_t FMT_J = 3'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } payload_t;

  // Arithmetic shift leaves all-zeros or all-ones only if the upper bits
  // are a pure sign extension.
  function automatic logic fits_signed(input logic [31:0] v, input int lsb);
    logic [31:0] sh;
    sh = $unsigned($signed(v) >>> lsb);
    return (sh == 32'h0) || (&sh);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: input and output valid/ready streams of the encoder.
//   in_valid/in_ready/in_fmt/in_base/in_imm  - request stream
//   out_valid/out_ready/out_inst/out_err     - encoded word stream
// Modports: slave (the encoder), master (the source/sink driving it).
interface imm_encoder_if;
  import imm_enc_pkg::*;

  logic        in_valid;
  logic        in_ready;
  fmt_t        in_fmt;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport slave (
    input  in_valid, in_fmt, in_base, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );

  modport master (
    output in_valid, in_fmt, in_base, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

endinterface

// File: rtl/imm_encoder_skid.sv
// imm_enc_skid: 2-entry valid/ready skid buffer carrying payload_t.
//   clk, rst                       - clock, synchronous active-high reset
//   in_valid/in_ready/in_data      - upstream side; in_ready is a flop
//   out_valid/out_ready/out_data   - downstream side; held stable while stalled
// The output register holds the presented word; the skid register catches
// one word accepted while the output is full and stalled.
module imm_enc_skid
  import imm_enc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  logic     out_full;
  logic     skid_full;
  logic     skid_full_nxt;
  logic     ready_q;
  payload_t out_q;
  payload_t skid_q;
  logic     in_hs;
  logic     drain;

  assign in_hs = in_valid && ready_q;
  // Output register can take a new word this cycle.
  assign drain = !out_full || out_ready;

  always_comb begin
    skid_full_nxt = skid_full;
    if (drain && skid_full)
      skid_full_nxt = 1'b0;
    else if (!drain && in_hs)
      skid_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
      ready_q   <= 1'b1;
      out_q     <= '0;
      skid_q    <= '0;
    end else begin
      skid_full <= skid_full_nxt;
      ready_q   <= !skid_full_nxt;
      if (drain) begin
        // Skid word always goes first to keep FIFO order; in_ready is low
        // whenever the skid is full, so no input competes with it.
        if (skid_full) begin
          out_q    <= skid_q;
          out_full <= 1'b1;
        end else if (in_hs) begin
          out_q    <= in_data;
          out_full <= 1'b1;
        end else begin
          out_full <= 1'b0;
        end
      end else if (in_hs) begin
        skid_q <= in_data;
      end
    end
  end

  assign in_ready  = ready_q;
  // Nothing is presented during a reset cycle.
  assign out_valid = out_full && !rst;
  assign out_data  = out_q;

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: streaming RV32I instruction-word assembler (inverse of the
// immediate generator). Scatters a 32-bit immediate into the base word
// according to the format code and flags range/alignment/format errors.
//   clk, rst   - clock, synchronous active-high reset
//   bus        - imm_encoder_if.slave (request and encoded-word streams)
//   err_seen   - sticky: an erroneous word was handed downstream
//   enc_count  - output handshakes since reset, wraps modulo 2^COUNT_W
// Macro IMM_ENC_JU_EN: when defined, U and J formats are encoded; otherwise
// fmt 3/4 are invalid and their range logic is not built.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  imm_encoder_if.slave       bus,
  output logic               err_seen,
  output logic [COUNT_W-1:0] enc_count
);

  logic [31:0] imm;
  payload_t    enc;
  payload_t    out_word;
  logic        out_hs;

  assign imm = bus.in_imm;

  // Encoding is purely combinational; the skid buffer captures it on accept.
  // Errors still produce the word built from the truncated immediate bits.
  always_comb begin
    enc.inst = bus.in_base;
    enc.err  = 1'b1;
    case (bus.in_fmt)
      FMT_I: begin
        enc.inst[31:20] = imm[11:0];
        enc.err         = !fits_signed(imm, 11);
      end
      FMT_S: begin
        enc.inst[31:25] = imm[11:5];
        enc.inst[11:7]  = imm[4:0];
        enc.err         = !fits_signed(imm, 11);
      end
      FMT_B: begin
        enc.inst[31]    = imm[12];
        enc.inst[30:25] = imm[10:5];
        enc.inst[11:8]  = imm[4:1];
        enc.inst[7]     = imm[11];
        enc.err         = !fits_signed(imm, 12) || imm[0];
      end
`ifdef IMM_ENC_JU_EN
      FMT_U: begin
        enc.inst[31:12] = imm[31:12];
        enc.err         = (imm[11:0] != 12'h0);
      end
      FMT_J: begin
        enc.inst[31]    = imm[20];
        enc.inst[30:21] = imm[10:1];
        enc.inst[20]    = imm[11];
        enc.inst[19:12] = imm[19:12];
        enc.err         = !fits_signed(imm, 20) || imm[0];
      end
`endif
      default: begin
        enc.inst = bus.in_base;
        enc.err  = 1'b1;
      end
    endcase
  end

  imm_enc_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (enc),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_word)
  );

  assign bus.out_inst = out_word.inst;
  assign bus.out_err  = out_word.err;
  assign out_hs       = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
      err_seen  <= 1'b0;
    end else if (out_hs) begin
      enc_count <= enc_count + COUNT_W'(1);
      if (out_word.err)
        err_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus randomized
// traffic compared against a behavioural model and a FIFO scoreboard.
module tb_imm_encoder;
  import imm_enc_pkg::*;

  localparam int COUNT_W = 16;
`ifdef IMM_ENC_JU_EN
  localparam bit JU = 1'b1;
`else
  localparam bit JU = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               err_seen;
  logic [COUNT_W-1:0] enc_count;

  imm_encoder_if bus ();

  imm_encoder #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_seen  (err_seen),
    .enc_count (enc_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Which immediate bit lands in instruction bit k (-1: copied from base).
  function automatic int imm_src(input int f, input int k);
    case (f)
      0: return (k >= 20) ? k - 20 : -1;
      1: begin
        if (k >= 25) return k - 20;
        if (k >= 7 && k <= 11) return k - 7;
        return -1;
      end
      2: begin
        if (k == 31) return 12;
        if (k >= 25) return k - 20;
        if (k >= 8 && k <= 11) return k - 7;
        if (k == 7) return 11;
        return -1;
      end
      3: return (k >= 12) ? k : -1;
      4: begin
        if (k == 31) return 20;
        if (k >= 21) return k - 20;
        if (k == 20) return 11;
        if (k >= 12) return k;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  // Returns {err, inst}.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] base,
                                        input logic [31:0] imm);
    longint v;
    logic [31:0] inst;
    logic err;
    int s;
    v = longint'($signed(imm));
    inst = base;
    err = 1'b1;
    if (f > 3'd4 || (!JU && f > 3'd2)) return {1'b1, base};
    for (int k = 0; k < 32; k++) begin
      s = imm_src(int'(f), k);
      if (s >= 0) inst[k] = imm[s];
    end
    case (f)
      3'd0, 3'd1: err = (v < -2048) || (v > 2047);
      3'd2:       err = (v < -4096) || (v > 4095) || (imm % 2 != 0);
      3'd3:       err = (imm % 4096) != 0;
      default:    err = (v < -(64'sd1 << 20)) || (v > (64'sd1 << 20) - 1) || (imm % 2 != 0);
    endcase
    return {err, inst};
  endfunction

  logic [32:0]        exp_q[$];
  logic [COUNT_W-1:0] model_count;
  logic               model_err_seen;
  logic               stalled;
  logic [32:0]        stall_word;
  int                 accepted;

  // One clock: sample at negedge, update scoreboard, return at posedge+1.
  task automatic step();
    logic ih, oh;
    logic [32:0] got, e;
    @(negedge clk);
    ih = bus.in_valid && bus.in_ready;
    oh = bus.out_valid && bus.out_ready;
    if (!rst) begin
      chk("enc_count", 64'(enc_count), 64'(model_count));
      chk("err_seen", 64'(err_seen), 64'(model_err_seen));
      if (stalled)
        chk("stall_hold", 64'({bus.out_valid, bus.out_err, bus.out_inst}), 64'({1'b1, stall_word}));
      if (oh) begin
        got = {bus.out_err, bus.out_inst};
        if (exp_q.size() == 0) begin
          chk("out_no_pending", 64'(bus.out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_word", 64'(got), 64'(e));
          if (e[32]) model_err_seen = 1'b1;
        end
        model_count = model_count + 1'b1;
      end
      if (ih) begin
        exp_q.push_back(model(bus.in_fmt, bus.in_base, bus.in_imm));
        accepted++;
      end
      stalled    = bus.out_valid && !bus.out_ready;
      stall_word = {bus.out_err, bus.out_inst};
    end else begin
      stalled = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_q.delete();
    model_count = '0;
    model_err_seen = 1'b0;
    stalled = 1'b0;
  endtask

  task automatic send_check(input string tag, input logic [2:0] f, input logic [31:0] base,
                            input logic [31:0] imm, input logic [31:0] x_inst, input logic x_err);
    int acc0;
    acc0 = accepted;
    bus.in_valid = 1'b1;
    bus.in_fmt = f;
    bus.in_base = base;
    bus.in_imm = imm;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_accept"}, 64'(accepted - acc0), 64'(1));
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_inst"}, 64'(bus.out_inst), 64'(x_inst));
    chk({tag, "_err"}, 64'(bus.out_err), 64'(x_err));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    budget = 20;
    while ((exp_q.size() != 0 || bus.out_valid) && budget > 0) begin
      step();
      budget--;
    end
    chk({tag, "_drain_left"}, 64'(exp_q.size()), 64'(0));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] bp_base [3];
    logic [COUNT_W-1:0] cnt0;
    int idx, acc0, budget;

    accepted = 0;
    model_count = '0;
    model_err_seen = 1'b0;
    stalled = 1'b0;
    bus.in_fmt = '0;
    bus.in_base = '0;
    bus.in_imm = '0;
    do_reset();
    do_reset();
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_inst", 64'(bus.out_inst), 64'(0));
    chk("rst_enc_count", 64'(enc_count), 64'(0));
    chk("rst_err_seen", 64'(err_seen), 64'(0));

    send_check("i_type", 3'd0, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    send_check("s_type", 3'd1, 32'h0020_A023, 32'd8, 32'h0020_A423, 1'b0);
    send_check("b_type", 3'd2, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    chk("err_seen_clean", 64'(err_seen), 64'(0));
    send_check("b_misalign", 3'd2, 32'h0000_0063, 32'd3, 32'h0000_0163, 1'b1);
    chk("err_seen_set", 64'(err_seen), 64'(1));
    send_check("i_range", 3'd0, 32'h0000_0013, 32'd2048, 32'h8000_0013, 1'b1);
    send_check("fmt_inv", 3'd6, 32'h1234_5678, 32'h0000_0ABC, 32'h1234_5678, 1'b1);
`ifdef IMM_ENC_JU_EN
    send_check("u_type", 3'd3, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0);
    send_check("j_type", 3'd4, 32'h0000_006F, 32'd2048, 32'h0010_006F, 1'b0);
`else
    send_check("u_off", 3'd3, 32'h0000_0037, 32'h1234_5000, 32'h0000_0037, 1'b1);
    send_check("j_off", 3'd4, 32'h0000_006F, 32'd2048, 32'h0000_006F, 1'b1);
`endif

    // Backpressure: three words offered with the sink stalled.
    bp_base[0] = 32'h0000_0093;
    bp_base[1] = 32'h0000_0113;
    bp_base[2] = 32'h0000_0193;
    cnt0 = model_count;
    bus.out_ready = 1'b0;
    bus.in_fmt = 3'd0;
    idx = 0;
    acc0 = accepted;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_base = bp_base[idx];
      bus.in_imm = 32'(idx + 1);
      step();
      if (accepted - acc0 > idx) idx++;
      if (c == 1) chk("bp_ready_low", 64'(bus.in_ready), 64'(0));
    end
    chk("bp_accepted", 64'(accepted - acc0), 64'(2));
    chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    budget = 10;
    while (idx < 3 && budget > 0) begin
      bus.in_valid = 1'b1;
      bus.in_base = bp_base[idx];
      bus.in_imm = 32'(idx + 1);
      step();
      if (accepted - acc0 > idx) idx++;
      budget--;
    end
    chk("bp_third_accept", 64'(idx), 64'(3));
    drain("bp");
    chk("bp_enc_count", 64'(enc_count), 64'(cnt0 + 3'd3));

    // Reset with both entries full.
    bus.out_ready = 1'b0;
    bus.in_fmt = 3'd2;
    bus.in_base = 32'h0000_0063;
    bus.in_imm = 32'd3;
    bus.in_valid = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_out_valid", 64'(bus.out_valid), 64'(1));
    do_reset();
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("mid_rst_enc_count", 64'(enc_count), 64'(0));
    chk("mid_rst_err_seen", 64'(err_seen), 64'(0));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_fmt = 3'($urandom_range(0, 7));
      bus.in_base = $urandom;
      case ($urandom_range(0, 4))
        0: bus.in_imm = $urandom;
        1: bus.in_imm = 32'($signed($urandom_range(0, 8191)) - 4096);
        2: bus.in_imm = 32'($urandom_range(0, 32'hFFFFF)) << 12;
        3: bus.in_imm = 32'($signed($urandom_range(0, 32'h1FFFFF)) - 32'sh100000) & ~32'h1;
        default: bus.in_imm = 32'($signed($urandom_range(0, 4095)) - 2048);
      endcase
      step();
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming instruction-word assembler; the inverse of the immediate generator.
- Takes a base RV32I instruction (opcode/register/funct fields valid) plus a 32-bit signed immediate and a format code. Scatters the immediate into the correct bit positions and flags range and alignment violations.
- Sits between the test/program loader and instruction memory. Uses a valid/ready handshake in and out, with a 2-entry skid buffer so in_ready is driven from a register.

Parameters:
- COUNT_W, 16, width of the accepted-output transaction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle; registered.
- in_fmt  in  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5-7 invalid.
- in_base  in  32  instruction with non-immediate fields; immediate bit positions are ignored and overwritten.
- in_imm  in  32  immediate value (byte offset for B/J; full upper value for U).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_inst  out  32  encoded instruction.
- out_err  out  1  this word had a range, alignment or format violation.
- err_seen  out  1  sticky: any violation emitted since reset.
- enc_count  out  COUNT_W  number of output handshakes since reset; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (synchronous): out_valid=0, out_inst=0, out_err=0, err_seen=0, enc_count=0, in_ready=1, skid empty. Reset asserted mid-stream drops all held words, and nothing is emitted in the reset cycle.
- Input handshake is in_valid&&in_ready. Output handshake is out_valid&&out_ready.
- Encoding is combinational from the input and captured on the input handshake. Latency is exactly 1 cycle to out_valid when the output stage is empty or draining.
- Bit placement. Bits not listed below are copied from in_base.
  - I: inst[31:20]=imm[11:0].
  - S: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12]; inst[7]=imm[11]; inst[30:25]=imm[10:5]; inst[11:8]=imm[4:1].
  - U: inst[31:12]=imm[31:12].
  - J: inst[31]=imm[20]; inst[30:21]=imm[10:1]; inst[20]=imm[11]; inst[19:12]=imm[19:12].
- Error rules. The word is still encoded from the truncated bits when an error is flagged.
  - I/S: error unless imm[31:11] are all equal.
  - B: error unless imm[31:12] are all equal and imm[0]=0.
  - U: error if imm[11:0]!=0.
  - J: error unless imm[31:20] are all equal and imm[0]=0.
  - fmt 5-7: out_inst=in_base unchanged, out_err=1.
- Skid buffer:
  - The output register holds the presented word. The skid register holds one word captured when the output register is full and not draining.
  - in_ready is the registered value of !skid_full.
  - When out_ready is high, the skid word moves to the output register before any new input.
  - Order is strictly FIFO. Simultaneous input and output handshakes sustain one word per cycle.
- out_inst, out_err and out_valid must stay stable while out_valid&&!out_ready.
- err_seen sets on the output handshake of a word with out_err=1 and clears only on rst.
- enc_count increments on each output handshake and wraps from all-ones to 0.

Optional Feature:
- IMM_ENC_JU_EN defined: U and J formats are encoded as above.
- IMM_ENC_JU_EN undefined: fmt 3 and 4 are treated as invalid (out_inst=in_base, out_err=1). The U/J range logic is not built.

Decomposition:
- Package imm_enc_pkg holds:
  - format code constants FMT_I/S/B/U/J;
  - a 3-bit fmt typedef;
  - a struct {inst[31:0], err} used as the buffer payload.
- Sub-module imm_enc_skid: a generic 2-entry valid/ready skid buffer carrying the payload struct. The top level holds the encode and check logic, err_seen and enc_count.

Test Plan:
- I-type: base=0x00000093, imm=0xFFFFFFFF, fmt=0 -> out_inst=0xFFF00093, out_err=0, one cycle after the handshake.
- S-type: base=0x0000A023 with rs2=2 (0x0020A023), imm=8, fmt=1 -> out_inst=0x0020A423, out_err=0.
- B-type: base=0x00000063, imm=0xFFFFFFFC, fmt=2 -> out_inst=0xFE000EE3. The same case with imm=3 gives out_err=1 and err_seen=1 after the output handshake.
- Range: fmt=0, imm=2048 -> out_inst[31:20]=0x800, out_err=1. fmt=6 -> out_inst=in_base, out_err=1.
- Backpressure: out_ready=0 while 3 inputs are offered -> 2 accepted, in_ready=0 from the cycle after the second accept. Raising out_ready drains the words in order, enc_count ends at 3, and there is no duplication or loss.
- Reset mid-stream: both entries full, then rst pulsed one cycle -> next cycle out_valid=0, in_ready=1, enc_count=0, err_seen=0.
